// File: rtl/ova_dvp_tx.sv
// ova_dvp_tx
//   DVP camera-port transmitter. Accepts a ready/valid RGB565 pixel stream and
//   replays it as byte-serial frames (high byte first) framed by href/vsync.
//   Used as a camera emulator in bench and loopback builds.
//
// Ports
//   clk           system clock, rising edge
//   i_rst         synchronous active-high reset
//   i_en          frame enable, looked at only in IDLE and at the end of a frame
//   i_data        RGB565 pixel
//   i_data_vld    i_data is valid
//   o_data_ready  pixel is taken this cycle (one cycle before each even href slot)
//   o_data        DVP byte, 0 whenever href is low
//   o_href        line-active qualifier
//   o_vsync       frame sync, high for the whole VSYNC period
//   o_pclk_en     byte strobe, high on every cycle outside IDLE
//   o_frame_done  one-cycle pulse on the last clock of the front porch
//   o_underrun    sticky: a pixel was missing when it was required
module ova_dvp_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_data,
  input  logic        i_data_vld,
  output logic        o_data_ready,
  output logic [7:0]  o_data,
  output logic        o_href,
  output logic        o_vsync,
  output logic        o_pclk_en,
  output logic        o_frame_done,
  output logic        o_underrun
);

  localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int V_MAX_AB = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int V_MAX_CD = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int V_MAX    = (V_MAX_AB > V_MAX_CD) ? V_MAX_AB : V_MAX_CD;
  localparam int HW       = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int VW       = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [HW-1:0] H_LAST      = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_HREF_LAST = HW'(2 * H_ACTIVE - 1);
  localparam logic [VW-1:0] VS_LAST     = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VB_LAST     = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VA_LAST     = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VF_LAST     = VW'(V_FRONT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  state_t        state_reg, state_next;
  logic [HW-1:0] h_cnt_reg, h_cnt_next;
  logic [VW-1:0] v_cnt_reg, v_cnt_next;
  logic [7:0]    low_byte_reg;

  logic line_end;
  logic href_next;
  logic pre_slot_next;
  logic frame_done_next;

  // Position of the next cycle. Outputs are registered from this, so every
  // output lines up with the state/counter registers of the same cycle.
  always_comb begin
    state_next = state_reg;
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    line_end   = (h_cnt_reg == H_LAST);

    if (state_reg == ST_IDLE) begin
      h_cnt_next = '0;
      v_cnt_next = '0;
      if (i_en) begin
        state_next = ST_VSYNC;
      end
    end else if (line_end) begin
      h_cnt_next = '0;
      v_cnt_next = v_cnt_reg + 1'b1;
      case (state_reg)
        ST_VSYNC: begin
          if (v_cnt_reg == VS_LAST) begin
            state_next = ST_VBACK;
            v_cnt_next = '0;
          end
        end
        ST_VBACK: begin
          if (v_cnt_reg == VB_LAST) begin
            state_next = ST_ACTIVE;
            v_cnt_next = '0;
          end
        end
        ST_ACTIVE: begin
          if (v_cnt_reg == VA_LAST) begin
            state_next = ST_VFRONT;
            v_cnt_next = '0;
          end
        end
        ST_VFRONT: begin
          if (v_cnt_reg == VF_LAST) begin
            state_next = i_en ? ST_VSYNC : ST_IDLE;
            v_cnt_next = '0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          v_cnt_next = '0;
        end
      endcase
    end else begin
      h_cnt_next = h_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    href_next = (state_next == ST_ACTIVE) && (h_cnt_next <= H_HREF_LAST);

    // The cycle after the next one is an even href slot: either an odd slot
    // inside the line, or the last clock of a line/back porch that leads into
    // another active line.
    pre_slot_next = 1'b0;
    if (state_next == ST_ACTIVE) begin
      pre_slot_next = (h_cnt_next[0] && (h_cnt_next < H_HREF_LAST)) ||
                      ((h_cnt_next == H_LAST) && (v_cnt_next != VA_LAST));
    end else if (state_next == ST_VBACK) begin
      pre_slot_next = (h_cnt_next == H_LAST) && (v_cnt_next == VB_LAST);
    end

    frame_done_next = (state_next == ST_VFRONT) && (v_cnt_next == VF_LAST) &&
                      (h_cnt_next == H_LAST);
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      h_cnt_reg    <= '0;
      v_cnt_reg    <= '0;
      low_byte_reg <= '0;
      o_data_ready <= 1'b0;
      o_data       <= '0;
      o_href       <= 1'b0;
      o_vsync      <= 1'b0;
      o_pclk_en    <= 1'b0;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      h_cnt_reg    <= h_cnt_next;
      v_cnt_reg    <= v_cnt_next;
      o_href       <= href_next;
      o_vsync      <= (state_next == ST_VSYNC);
      o_pclk_en    <= (state_next != ST_IDLE);
      o_frame_done <= frame_done_next;
      o_data_ready <= pre_slot_next;

      // A ready cycle is always followed by an even slot, so the pixel taken
      // here goes straight out; a missing pixel is sent as two zero bytes.
      if (o_data_ready) begin
        o_data       <= i_data_vld ? i_data[15:8] : 8'h00;
        low_byte_reg <= i_data_vld ? i_data[7:0]  : 8'h00;
      end else if (href_next) begin
        o_data <= low_byte_reg;
      end else begin
        o_data <= 8'h00;
      end

      // Cleared on entering IDLE and while there, so a fresh IDLE -> VSYNC
      // start always begins clean; back-to-back frames keep it.
      if ((state_reg == ST_IDLE) || (state_next == ST_IDLE)) begin
        o_underrun <= 1'b0;
      end else if (o_data_ready && !i_data_vld) begin
        o_underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ova_dvp_tx.sv
module tb_ova_dvp_tx;

  localparam int H_ACTIVE    = 4;
  localparam int H_BLANK     = 2;
  localparam int V_ACTIVE    = 2;
  localparam int VSYNC_LINES = 1;
  localparam int V_BACK      = 1;
  localparam int V_FRONT     = 1;
  localparam int LL          = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME       = LL * (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT);
  localparam int ACT_START   = VSYNC_LINES + V_BACK;
  localparam int PIX_FRAME   = H_ACTIVE * V_ACTIVE;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic [15:0] i_data = 16'h0000;
  logic        i_data_vld = 1'b0;
  logic        o_data_ready;
  logic [7:0]  o_data;
  logic        o_href;
  logic        o_vsync;
  logic        o_pclk_en;
  logic        o_frame_done;
  logic        o_underrun;

  always #5 clk = ~clk;

  ova_dvp_tx #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_data       (i_data),
    .i_data_vld   (i_data_vld),
    .o_data_ready (o_data_ready),
    .o_data       (o_data),
    .o_href       (o_href),
    .o_vsync      (o_vsync),
    .o_pclk_en    (o_pclk_en),
    .o_frame_done (o_frame_done),
    .o_underrun   (o_underrun)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: t is the cycle index inside the current frame, -1 in IDLE.
  int         t = -1;
  bit         und = 1'b0;
  logic [7:0] byte_q[$];

  function automatic bit href_at(int p);
    int line;
    int h;
    if (p < 0 || p >= FRAME) return 1'b0;
    line = p / LL;
    h    = p % LL;
    return (line >= ACT_START) && (line < ACT_START + V_ACTIVE) && (h < 2 * H_ACTIVE);
  endfunction

  function automatic bit ready_at(int p);
    if (p < 0) return 1'b0;
    return href_at(p + 1) && (((p + 1) % LL) % 2 == 0);
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
    end
  endtask

  // Model update on each rising edge, from the inputs the DUT sees there.
  initial begin
    forever begin
      @(posedge clk);
      if (i_rst) begin
        t   = -1;
        und = 1'b0;
        byte_q.delete();
      end else begin
        if (ready_at(t)) begin
          if (i_data_vld) begin
            byte_q.push_back(i_data[15:8]);
            byte_q.push_back(i_data[7:0]);
          end else begin
            byte_q.push_back(8'h00);
            byte_q.push_back(8'h00);
            und = 1'b1;
          end
        end
        if (t < 0) begin
          if (i_en) begin
            t   = 0;
            und = 1'b0;
          end
        end else if (t == FRAME - 1) begin
          if (i_en) begin
            t = 0;
          end else begin
            t   = -1;
            und = 1'b0;
          end
        end else begin
          t++;
        end
      end
    end
  end

  // Monitor: compares every output on the falling edge.
  int         rdy_cnt = 0;
  bit         prev_ready = 1'b0;
  int         byte_n = 0;
  logic [7:0] exp_b;
  logic [7:0] exp_hi;
  logic [7:0] got_hi;

  initial begin
    forever begin
      @(negedge clk);
      chk("pclk_en", int'(o_pclk_en), int'(t >= 0));
      chk("vsync", int'(o_vsync), int'(t >= 0 && t < VSYNC_LINES * LL));
      chk("href", int'(o_href), int'(href_at(t)));
      chk("ready", int'(o_data_ready), int'(ready_at(t)));
      chk("frame_done", int'(o_frame_done), int'(t == FRAME - 1));
      chk("underrun", int'(o_underrun), int'(und));
      chk("ready_consecutive", int'(o_data_ready && prev_ready), 0);
      chk("ready_in_vsync", int'(o_data_ready && o_vsync), 0);
      prev_ready = o_data_ready;

      if (t == 0) rdy_cnt = 0;
      if (o_data_ready) rdy_cnt++;
      if (t == FRAME - 1) chk("ready_per_frame", rdy_cnt, PIX_FRAME);

      if (o_href) begin
        if (byte_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL data_queue_empty t=%0d got=%02h exp=none", t, o_data);
        end else begin
          exp_b = byte_q.pop_front();
          chk("data", int'(o_data), int'(exp_b));
          if (byte_n % 2 == 0) begin
            exp_hi = exp_b;
            got_hi = o_data;
          end else begin
            $display("PIX %0d t=%0d got=%02h%02h exp=%02h%02h", byte_n / 2, t,
                     got_hi, o_data, exp_hi, exp_b);
          end
          byte_n++;
        end
      end else begin
        chk("data_idle", int'(o_data), 0);
        byte_n = 0;
      end
    end
  end

  // Source: holds a pixel until it is taken, then moves to the next one.
  int          pix_n = 0;
  logic [15:0] pix = 16'hA1B2;
  bit          acc_flag = 1'b0;
  int          vld_mode = 0;   // 0 always valid, 1 random, 2 drop 3rd ready
  int          rdy_seen = 0;

  function automatic logic [15:0] next_pix(int n);
    if (n == 0) return 16'hA1B2;
    if (n == 1) return 16'hC3D4;
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic step();
    @(negedge clk);
    if (acc_flag) begin
      pix_n++;
      pix = next_pix(pix_n);
    end
    if (o_vsync) rdy_seen = 0;
    case (vld_mode)
      0:       i_data_vld = 1'b1;
      1:       i_data_vld = ($urandom_range(0, 99) < 80);
      default: i_data_vld = !(o_data_ready && rdy_seen == 2);
    endcase
    if (o_data_ready) rdy_seen++;
    i_data   = pix;
    acc_flag = o_data_ready && i_data_vld;
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (3) step();
    i_rst = 1'b0;
    repeat (3) step();

    // Back-to-back frames with an always-valid source.
    vld_mode = 0;
    i_en = 1'b1;
    repeat (2 * FRAME) step();

    // Missing pixel at the 3rd ready, then a frame where underrun stays set.
    vld_mode = 2;
    repeat (FRAME) step();
    vld_mode = 0;
    repeat (25) step();

    // Drop enable mid-frame: the frame completes, then IDLE.
    i_en = 1'b0;
    repeat (FRAME + 5) step();

    // Reset in the middle of an active line, then a clean restart.
    i_en = 1'b1;
    repeat (34) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    repeat (FRAME + 10) step();

    // Random valid and enable toggling, occasional reset.
    vld_mode = 1;
    repeat (8 * FRAME) begin
      if ($urandom_range(0, 99) < 3) i_en = ~i_en;
      i_rst = ($urandom_range(0, 299) == 0);
      step();
    end
    i_rst = 1'b0;
    i_en = 1'b0;
    repeat (2 * FRAME + 5) step();

    chk("queue_empty", byte_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
